forward_scoreboard: RTL and testbench

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fwd_priority_sel.sv | 36 +++
 rtl/forward_scoreboard.sv | 149 ++++++++++++++
 tb/tb_forward_scoreboard.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the integer pipeline hazard logic.
//   reg_addr_t       : architectural register index (x0..x31)
//   FWD_SEL_REGFILE  : forward-select code meaning "read the register file"
// Widths that depend on pipeline parameters stay local to their modules.
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int NUM_ARCH_REGS   = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int FWD_SEL_REGFILE = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/fwd_priority_sel.sv
// -----------------------------------------------------------------------------
// fwd_priority_sel
// Picks the forwarding source for one operand. The youngest stage holding a
// write to the operand's register wins. x0 always reads the register file,
// because x0 is hard-wired to zero and must never pick up a stale stage value.
// Ports:
//   rs        in  : operand register address
//   fwd_valid in  : per stage, stage holds a register write
//   fwd_rd    in  : per stage, destination register held
//   sel       out : FWD_SEL_REGFILE, or k+1 for stage k
// -----------------------------------------------------------------------------
module fwd_priority_sel
    import riscv_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  reg_addr_t                   rs,
    input  logic      [NUM_FWD-1:0]     fwd_valid,
    input  reg_addr_t [NUM_FWD-1:0]     fwd_rd,
    output logic      [SEL_W-1:0]       sel
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel = SEL_W'(FWD_SEL_REGFILE);
        if (rs != '0) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_valid[k] && (fwd_rd[k] == rs)) begin
                    sel = SEL_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// -----------------------------------------------------------------------------
// forward_scoreboard
// Register scoreboard for the ID/EX issue point. Each register x1..x31 owns a
// down-counter holding the number of cycles until its pending result becomes
// forwardable. A source with a count above 1 is a RAW hazard; a count of 1
// means the value is in a forwarding stage this cycle and is bypassed instead.
// A destination whose pending write would retire after the new one is a WAW
// hazard (out-of-order completion) and also stalls.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   issue_valid      : instruction presented for issue
//   issue_rs         : per source operand register
//   issue_rd         : destination register
//   issue_reg_write  : instruction writes issue_rd
//   issue_lat        : cycles until forwardable (0 = next cycle), clamped
//   fwd_valid/fwd_rd : per forwarding stage write information (0 = youngest)
//   flush            : discard all pending writes
//   stall            : issue held this cycle (combinational)
//   fwd_sel          : per source, 0 = register file, k+1 = stage k
//   busy             : per-register pending flag (bit 0 always 0)
//   stall_cycles     : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module forward_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int MAX_LAT = 8,
    parameter int LAT_W   = $clog2(MAX_LAT + 1),
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              issue_valid,
    input  reg_addr_t [NUM_SRC-1:0]           issue_rs,
    input  reg_addr_t                         issue_rd,
    input  logic                              issue_reg_write,
    input  logic      [LAT_W-1:0]             issue_lat,
    input  logic      [NUM_FWD-1:0]           fwd_valid,
    input  reg_addr_t [NUM_FWD-1:0]           fwd_rd,
    input  logic                              flush,
    output logic                              stall,
    output logic      [NUM_SRC-1:0][SEL_W-1:0] fwd_sel,
    output logic      [31:0]                  busy,
    output logic      [31:0]                  stall_cycles
);

    // Counters must hold MAX_LAT+1, which can need one bit more than LAT_W
    // when MAX_LAT+1 is a power of two.
    localparam int CNT_W = $clog2(MAX_LAT + 2);

    logic [CNT_W-1:0] cnt_q [NUM_ARCH_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_ARCH_REGS];
    logic [31:0]      stall_cycles_q;
    logic [31:0]      stall_cycles_d;

    logic [LAT_W-1:0] lat_clamped;
    logic [CNT_W-1:0] set_val;
    logic             raw_hit;
    logic             waw_hit;
    logic             stall_int;
    logic             issue_accept;
    logic             do_write;

    logic [NUM_SRC-1:0][SEL_W-1:0] sel_raw;

    always_comb begin
        lat_clamped = (issue_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : issue_lat;
        set_val     = CNT_W'(lat_clamped) + CNT_W'(1);
    end

    // Hazard detection. A count of exactly 1 is covered by forwarding, so only
    // counts above 1 block a source. For WAW, the new write completes after
    // set_val cycles; an older write finishing later would clobber it.
    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((issue_rs[i] != '0) && (cnt_q[issue_rs[i]] > CNT_W'(1))) begin
                raw_hit = 1'b1;
            end
        end
        waw_hit = issue_reg_write && (issue_rd != '0) && (cnt_q[issue_rd] > set_val);
    end

    // Flush and reset both suppress the stall so the front end is never held
    // by writes that are being discarded.
    assign stall_int    = rst_n && issue_valid && !flush && (raw_hit || waw_hit);
    assign issue_accept = rst_n && issue_valid && !flush && !stall_int;
    assign do_write     = issue_accept && issue_reg_write && (issue_rd != '0);

    // Counter next-state: x0 stays zero, flush clears, a new issue overrides
    // the decrement of the same register.
    always_comb begin
        for (int r = 0; r < NUM_ARCH_REGS; r++) begin
            cnt_d[r] = '0;
            if ((r != 0) && !flush) begin
                if (do_write && (issue_rd == REG_ADDR_W'(r))) begin
                    cnt_d[r] = set_val;
                end else if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
            end
        end
    end

    assign stall_cycles_d = (stall_int && (stall_cycles_q != '1)) ?
                            stall_cycles_q + 32'd1 : stall_cycles_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int r = 0; r < NUM_ARCH_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_ARCH_REGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src_sel
            fwd_priority_sel #(
                .NUM_FWD (NUM_FWD),
                .SEL_W   (SEL_W)
            ) u_sel (
                .rs        (issue_rs[gi]),
                .fwd_valid (fwd_valid),
                .fwd_rd    (fwd_rd),
                .sel       (sel_raw[gi])
            );
        end
    endgenerate

    assign fwd_sel      = rst_n ? sel_raw : '0;
    assign stall        = stall_int;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_forward_scoreboard
// Directed scenarios followed by random traffic. The reference model records,
// per register, the absolute cycle at which its pending write is done; the
// remaining latency is derived from the current cycle number.
// -----------------------------------------------------------------------------
module tb_forward_scoreboard;
    import riscv_pkg::*;

    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 2;
    localparam int MAX_LAT = 8;
    localparam int LAT_W   = 4;
    localparam int SEL_W   = 2;

    logic                              clk = 1'b0;
    logic                              rst_n = 1'b0;
    logic                              issue_valid = 1'b0;
    reg_addr_t [NUM_SRC-1:0]           issue_rs = '0;
    reg_addr_t                         issue_rd = '0;
    logic                              issue_reg_write = 1'b0;
    logic      [LAT_W-1:0]             issue_lat = '0;
    logic      [NUM_FWD-1:0]           fwd_valid = '0;
    reg_addr_t [NUM_FWD-1:0]           fwd_rd = '0;
    logic                              flush = 1'b0;
    logic                              stall;
    logic      [NUM_SRC-1:0][SEL_W-1:0] fwd_sel;
    logic      [31:0]                  busy;
    logic      [31:0]                  stall_cycles;

    int          compared   = 0;
    int          mismatched = 0;
    int          done_at [32];
    int          t = 0;
    int unsigned m_stalls = 0;

    forward_scoreboard #(
        .NUM_SRC (NUM_SRC),
        .NUM_FWD (NUM_FWD),
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W),
        .SEL_W   (SEL_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (issue_valid),
        .issue_rs        (issue_rs),
        .issue_rd        (issue_rd),
        .issue_reg_write (issue_reg_write),
        .issue_lat       (issue_lat),
        .fwd_valid       (fwd_valid),
        .fwd_rd          (fwd_rd),
        .flush           (flush),
        .stall           (stall),
        .fwd_sel         (fwd_sel),
        .busy            (busy),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_cnt(input int r);
        return (done_at[r] > t) ? (done_at[r] - t) : 0;
    endfunction

    function automatic int m_lat();
        return (int'(issue_lat) > MAX_LAT) ? MAX_LAT : int'(issue_lat);
    endfunction

    function automatic bit m_stall();
        if (!rst_n || !issue_valid || flush) return 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (issue_rs[i] != 0 && m_cnt(int'(issue_rs[i])) > 1) return 1'b1;
        if (issue_reg_write && issue_rd != 0 && m_cnt(int'(issue_rd)) > m_lat() + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_sel(input int i);
        if (!rst_n || issue_rs[i] == 0) return 0;
        for (int k = 0; k < NUM_FWD; k++)
            if (fwd_valid[k] && fwd_rd[k] == issue_rs[i]) return k + 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) b[r] = (m_cnt(r) != 0);
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // Compare against the model, then advance one clock and update the model
    // with the inputs that were applied during that cycle.
    task automatic cycle();
        bit st;
        bit acc;
        #1;
        st  = m_stall();
        acc = rst_n && issue_valid && !flush && !st;
        check("stall", 32'(stall), 32'(st));
        for (int i = 0; i < NUM_SRC; i++) check("fwd_sel", 32'(fwd_sel[i]), 32'(m_sel(i)));
        check("busy", busy, m_busy());
        check("stall_cycles", stall_cycles, m_stalls);
        @(posedge clk);
        if (!rst_n || flush) begin
            for (int r = 0; r < 32; r++) done_at[r] = 0;
        end else if (acc && issue_reg_write && issue_rd != 0) begin
            done_at[issue_rd] = t + 1 + m_lat() + 1;
        end
        if (!rst_n) m_stalls = 0;
        else if (st && m_stalls != 32'hFFFF_FFFF) m_stalls++;
        t++;
        @(negedge clk);
    endtask

    task automatic quiet();
        issue_valid     = 1'b0;
        issue_reg_write = 1'b0;
        issue_rs        = '0;
        issue_rd        = '0;
        issue_lat       = '0;
        fwd_valid       = '0;
        fwd_rd          = '0;
        flush           = 1'b0;
    endtask

    task automatic issue(input int rd, input int lat);
        quiet();
        issue_valid     = 1'b1;
        issue_reg_write = 1'b1;
        issue_rd        = 5'(rd);
        issue_lat       = 4'(lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int r = 0; r < 32; r++) done_at[r] = 0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_busy", busy, 32'd0);
        check("reset_stall_cycles", stall_cycles, 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Long-latency RAW: three stalled cycles then release
        issue(7, 3);
        cycle();
        quiet();
        issue_valid = 1'b1;
        issue_rs[1] = 5'd7;
        for (int n = 0; n < 3; n++) begin
            #1;
            check("raw_lat3_stall", 32'(stall), 32'd1);
            cycle();
        end
        #1;
        check("raw_lat3_release", 32'(stall), 32'd0);
        check("raw_lat3_count", stall_cycles, 32'd3);
        cycle();
        quiet();
        repeat (10) cycle();

        // Zero-latency producer forwarded from the youngest stage
        issue(5, 0);
        cycle();
        quiet();
        issue_valid  = 1'b1;
        issue_rs[0]  = 5'd5;
        fwd_valid    = 2'b01;
        fwd_rd[0]    = 5'd5;
        #1;
        check("fwd_lat0_stall", 32'(stall), 32'd0);
        check("fwd_lat0_sel", 32'(fwd_sel[0]), 32'd1);
        cycle();
        quiet();
        repeat (3) cycle();

        // Priority between stages
        issue_rs[0] = 5'd9;
        fwd_valid   = 2'b11;
        fwd_rd[0]   = 5'd9;
        fwd_rd[1]   = 5'd9;
        #1;
        check("prio_youngest", 32'(fwd_sel[0]), 32'd1);
        cycle();
        fwd_valid = 2'b10;
        #1;
        check("prio_stage1", 32'(fwd_sel[0]), 32'd2);
        cycle();
        quiet();

        // x0 destination and source
        issue(0, 5);
        cycle();
        quiet();
        issue_valid = 1'b1;
        fwd_valid   = 2'b11;
        #1;
        check("x0_busy", busy, 32'd0);
        check("x0_stall", 32'(stall), 32'd0);
        check("x0_sel", 32'(fwd_sel[0]), 32'd0);
        cycle();
        quiet();

        // WAW: second write to x3 waits until the older one is no later
        issue(3, 6);
        cycle();
        issue(3, 1);
        for (int n = 0; n < 5; n++) begin
            #1;
            check("waw_stall", 32'(stall), 32'd1);
            cycle();
        end
        #1;
        check("waw_release", 32'(stall), 32'd0);
        cycle();
        quiet();
        #1;
        check("waw_busy3", 32'(busy[3]), 32'd1);
        repeat (10) cycle();

        // Flush overrides issue and clears counters
        issue(12, 4);
        cycle();
        issue(4, 2);
        issue_rs[0] = 5'd12;
        flush       = 1'b1;
        #1;
        check("flush_stall", 32'(stall), 32'd0);
        cycle();
        quiet();
        #1;
        check("flush_busy", busy, 32'd0);
        cycle();

        // Reset in the middle of a count
        issue(12, 4);
        cycle();
        quiet();
        issue_valid = 1'b1;
        issue_rs[0] = 5'd12;
        fwd_valid   = 2'b01;
        fwd_rd[0]   = 5'd12;
        rst_n       = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_sel", 32'(fwd_sel[0]), 32'd0);
        cycle();
        rst_n = 1'b1;
        quiet();
        #1;
        check("rst_busy", busy, 32'd0);
        check("rst_count", stall_cycles, 32'd0);
        cycle();

        // Random traffic on a small register set, including clamped latencies
        for (int n = 0; n < 600; n++) begin
            issue_valid     = ($urandom_range(0, 3) != 0);
            issue_reg_write = 1'($urandom_range(0, 1));
            issue_rd        = 5'($urandom_range(0, 7));
            for (int i = 0; i < NUM_SRC; i++) issue_rs[i] = 5'($urandom_range(0, 7));
            issue_lat       = 4'($urandom_range(0, 15));
            fwd_valid       = 2'($urandom_range(0, 3));
            for (int k = 0; k < NUM_FWD; k++) fwd_rd[k] = 5'($urandom_range(0, 7));
            flush           = ($urandom_range(0, 29) == 0);
            rst_n           = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
